fcore_program_sequencer: RTL and testbench
==========================================

Name: fcore_program_sequencer

Overview:
- Drives instruction-memory fetch addresses and channel indices into the fCore prefetch/decode stage.
- Sweeps every channel for each instruction word, then advances the program counter: by 2 after a load-constant (LDC) word pair, by 1 otherwise.
- Stalls the fetch stream during external function (EFI) calls.
- Terminates on a STOP opcode or at the end of the program.

Parameters:
- PC_WIDTH, 12, instruction-memory word address width.
- MAX_CHANNELS, 255, maximum channel count. CW = $clog2(MAX_CHANNELS).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- run, input, 1, start pulse; ignored while busy.
- n_channels, input, CW, channels per instruction; 0 is treated as 1; sampled on run.
- program_size, input, PC_WIDTH, address bound; sampled on run.
- immediate_advance, input, 1, decode flag: word fetched last cycle is LDC.
- efi_call, input, 1, decode flag: word fetched last cycle is EFI.
- stop_detected, input, 1, decode flag: word fetched last cycle is STOP.
- efi_done, input, 1, pulse from the EFI unit: call complete.
- fetch_address, output, PC_WIDTH, instruction-memory read address.
- fetch_enable, output, 1, read strobe; memory latency is 1 cycle.
- channel_address, output, CW, channel of the current beat.
- efi_pending, output, 1, high while waiting for efi_done.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at program end.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-program):
  - state goes to IDLE.
  - All outputs go to 0.
  - pc, channel counter and latched flags are cleared.
- States: IDLE, FETCH, ADVANCE, EFI_WAIT, DONE.
- IDLE:
  - Outputs are 0.
  - On run: latch n_eff = max(n_channels, 1) and program_size; set pc = 0, ch = 0; go to FETCH.
- FETCH, one beat per cycle:
  - fetch_enable = 1, fetch_address = pc, channel_address = ch.
  - ch increments each beat.
  - After the beat with ch == n_eff-1: reset ch to 0 and go to ADVANCE.
- Flag capture:
  - Decode flags are valid exactly one cycle after the first beat (ch == 0) of a word.
  - A registered first_beat_d marks that cycle; the flags are latched into ldc_f, efi_f and stop_f.
  - In ADVANCE, the effective flags are the live inputs if first_beat_d is high (the n_eff == 1 case), otherwise the latched values.
  - Flags in all other cycles are ignored.
- ADVANCE (one bubble cycle, fetch_enable = 0). Priority order:
  1. stop goes to DONE.
  2. efi goes to EFI_WAIT.
  3. ldc: pc += 2.
  4. otherwise: pc += 1.
- After the pc update: if new pc >= program_size, go to DONE; else go to FETCH.
- pc arithmetic is PC_WIDTH modulo. A wrap to a value below program_size is impossible when program_size <= 2^PC_WIDTH - 2, which is a documented constraint.
- EFI_WAIT:
  - efi_pending = 1, fetch_enable = 0.
  - On efi_done: pc += 1, then apply the program_size check; go to FETCH or DONE.
  - efi_done in any other state is ignored.
- DONE: done = 1 for exactly one cycle; busy = 1; then go to IDLE.
- run while busy (including DONE) is ignored. A run arriving the cycle after DONE starts a new program.
- program_size == 0: the first word is still fetched for all channels, then ADVANCE goes to DONE.
- Latency:
  - run to first fetch_enable: 1 cycle.
  - Each non-EFI word costs n_eff + 1 cycles.
- fetch_address and channel_address hold their last values in non-FETCH states, except in IDLE, where they are 0.

Test Plan:
- Plain sweep: run, n_channels = 3, program_size = 4, no flags.
  - fetch_address 0,0,0 / 1,1,1 / 2,2,2 / 3,3,3 with channel_address 0,1,2 on each, one bubble between words.
  - done pulses once, 4 cycles after the last beat is not allowed; done asserts in the cycle after the final ADVANCE.
  - busy returns low the following cycle.
- LDC skip: n_channels = 2, immediate_advance asserted the cycle after the first beat of address 1, program_size = 5.
  - Fetched addresses are 0, 1, 3, 4; address 2 is never fetched.
- n_channels = 1 with LDC at address 0 (flag arrives during the ADVANCE cycle): next fetch_address = 2.
- n_channels = 0: behaves as 1 channel; channel_address stays 0.
- EFI: efi_call on address 2, efi_done 10 cycles later.
  - efi_pending high for those cycles, fetch_enable low.
  - Fetch resumes at address 3.
  - An efi_done pulse in FETCH is ignored.
- STOP and abort cases:
  - stop_detected on address 1, program_size = 100: done pulses after the address-1 sweep; no further fetch.
  - run pulsed mid-program: ignored.
  - reset asserted mid-FETCH: all outputs 0 the next cycle, state IDLE; a new run restarts at pc = 0.

Source files
------------

// File: rtl/fcore_program_sequencer.sv
// fcore_program_sequencer: walks the program counter and channel index that feed
// instruction fetch, sweeping all channels per word and pausing for EFI calls.
module fcore_program_sequencer #(
    parameter int PC_WIDTH = 12,
    parameter int MAX_CHANNELS = 255,
    localparam int CW = $clog2(MAX_CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [CW-1:0]       n_channels,
    input  logic [PC_WIDTH-1:0] program_size,
    input  logic                immediate_advance,
    input  logic                efi_call,
    input  logic                stop_detected,
    input  logic                efi_done,
    output logic [PC_WIDTH-1:0] fetch_address,
    output logic                fetch_enable,
    output logic [CW-1:0]       channel_address,
    output logic                efi_pending,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, FETCH, ADVANCE, EFI_WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, size_q, size_d;
    logic [CW-1:0] ch_q, ch_d, n_eff_q, n_eff_d;
    logic first_beat_q, first_beat_d;
    logic ldc_f_q, ldc_f_d, efi_f_q, efi_f_d, stop_f_q, stop_f_d;
    logic [PC_WIDTH-1:0] fetch_address_q, fetch_address_d;
    logic [CW-1:0] channel_address_q, channel_address_d;
    logic fetch_enable_q, fetch_enable_d, efi_pending_q, efi_pending_d;
    logic busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        ch_d = ch_q;
        n_eff_d = n_eff_q;
        size_d = size_q;
        first_beat_d = (state_q == FETCH) && (ch_q == '0);
        // flags arrive one cycle after the first beat; with a single channel that cycle is ADVANCE itself
        ldc_f_d = first_beat_q ? immediate_advance : ldc_f_q;
        efi_f_d = first_beat_q ? efi_call : efi_f_q;
        stop_f_d = first_beat_q ? stop_detected : stop_f_q;
        case (state_q)
            IDLE: if (run) begin
                n_eff_d = (n_channels == '0) ? CW'(1) : n_channels;
                size_d = program_size;
                pc_d = '0;
                ch_d = '0;
                state_d = FETCH;
            end
            FETCH: if (ch_q == n_eff_q - CW'(1)) begin
                ch_d = '0;
                state_d = ADVANCE;
            end else begin
                ch_d = ch_q + CW'(1);
            end
            ADVANCE: if (stop_f_d) begin
                state_d = DONE;
            end else if (efi_f_d) begin
                state_d = EFI_WAIT;
            end else begin
                pc_d = pc_q + (ldc_f_d ? PC_WIDTH'(2) : PC_WIDTH'(1));
                state_d = (pc_d >= size_q) ? DONE : FETCH;
            end
            EFI_WAIT: if (efi_done) begin
                pc_d = pc_q + PC_WIDTH'(1);
                state_d = (pc_d >= size_q) ? DONE : FETCH;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        fetch_enable_d = state_d == FETCH;
        efi_pending_d = state_d == EFI_WAIT;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        fetch_address_d = (state_d == IDLE) ? '0 : (state_d == FETCH) ? pc_d : fetch_address_q;
        channel_address_d = (state_d == IDLE) ? '0 : (state_d == FETCH) ? ch_d : channel_address_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= '0;
            ch_q <= '0;
            n_eff_q <= '0;
            size_q <= '0;
            first_beat_q <= 1'b0;
            ldc_f_q <= 1'b0;
            efi_f_q <= 1'b0;
            stop_f_q <= 1'b0;
            fetch_address_q <= '0;
            channel_address_q <= '0;
            fetch_enable_q <= 1'b0;
            efi_pending_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            ch_q <= ch_d;
            n_eff_q <= n_eff_d;
            size_q <= size_d;
            first_beat_q <= first_beat_d;
            ldc_f_q <= ldc_f_d;
            efi_f_q <= efi_f_d;
            stop_f_q <= stop_f_d;
            fetch_address_q <= fetch_address_d;
            channel_address_q <= channel_address_d;
            fetch_enable_q <= fetch_enable_d;
            efi_pending_q <= efi_pending_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign fetch_address = fetch_address_q;
    assign channel_address = channel_address_q;
    assign fetch_enable = fetch_enable_q;
    assign efi_pending = efi_pending_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_fcore_program_sequencer.sv
// tb_fcore_program_sequencer: random programs run against a trace-level model of the sequencer.
module tb_fcore_program_sequencer;
    logic clock = 1'b0;
    logic reset, run, immediate_advance, efi_call, stop_detected, efi_done;
    logic [7:0] n_channels, channel_address;
    logic [11:0] program_size, fetch_address;
    logic fetch_enable, efi_pending, busy, done;

    fcore_program_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .n_channels(n_channels),
        .program_size(program_size), .immediate_advance(immediate_advance),
        .efi_call(efi_call), .stop_detected(stop_detected), .efi_done(efi_done),
        .fetch_address(fetch_address), .fetch_enable(fetch_enable),
        .channel_address(channel_address), .efi_pending(efi_pending),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic fe;
        logic [11:0] addr;
        logic [7:0] ch;
        logic pend;
        logic busy;
        logic done;
    } exp_t;

    localparam int NOP = 0, LDC = 1, EFI = 2, STOP = 3;
    int prog [0:4095];
    exp_t q[$];
    int compared = 0, mismatched = 0, cycle = 0;
    string obs;
    bit start_req = 0;
    int req_n, req_size, req_d, efi_cnt = 0;
    bit prev_fb = 0;
    int prev_addr = 0;

    task automatic chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cycle, act, exp);
        end
    endtask

    task automatic chk_str(string name, string act, string exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got \"%s\", want \"%s\"", name, act, exp);
        end
    endtask

    task automatic push(bit fe, int addr, int ch, bit pend, bit dn);
        exp_t e;
        e.fe = fe;
        e.addr = 12'(addr);
        e.ch = 8'(ch);
        e.pend = pend;
        e.busy = 1'b1;
        e.done = dn;
        q.push_back(e);
    endtask

    // expected output of every cycle from the first fetch to the done pulse
    task automatic build(int n, int size, int d);
        int ne, pc, npc;
        bit fin;
        ne = (n == 0) ? 1 : n;
        pc = 0;
        fin = 0;
        while (!fin) begin
            for (int c = 0; c < ne; c++) push(1, pc, c, 0, 0);
            push(0, pc, ne - 1, 0, 0);
            if (prog[pc] == STOP) begin
                push(0, pc, ne - 1, 0, 1);
                fin = 1;
            end else begin
                if (prog[pc] == EFI) begin
                    for (int i = 0; i < d; i++) push(0, pc, ne - 1, 1, 0);
                    npc = pc + 1;
                end else begin
                    npc = pc + ((prog[pc] == LDC) ? 2 : 1);
                end
                npc = npc % 4096;
                if (npc >= size) begin
                    push(0, pc, ne - 1, 0, 1);
                    fin = 1;
                end
                pc = npc;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        int p;
        @(negedge clock);
        cycle++;
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        chk("fetch_enable", int'(fetch_enable), int'(e.fe));
        chk("fetch_address", int'(fetch_address), int'(e.addr));
        chk("channel_address", int'(channel_address), int'(e.ch));
        chk("efi_pending", int'(efi_pending), int'(e.pend));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        if (fetch_enable && channel_address == 8'd0) obs = {obs, $sformatf("%0d ", fetch_address)};
        // decode flags are true only the cycle after a first beat; otherwise junk the DUT must ignore
        if (prev_fb) begin
            p = prog[prev_addr];
            {immediate_advance, efi_call, stop_detected} = (p == LDC) ? 3'b100 : (p == EFI) ? 3'b010 : (p == STOP) ? 3'b001 : 3'b000;
        end else begin
            {immediate_advance, efi_call, stop_detected} = 3'($urandom);
        end
        prev_fb = fetch_enable && channel_address == 8'd0;
        prev_addr = int'(fetch_address);
        if (efi_pending) begin
            efi_cnt++;
            efi_done = (efi_cnt == req_d);
        end else begin
            efi_cnt = 0;
            efi_done = ($urandom_range(3) == 0);
        end
        if (start_req) begin
            run = 1'b1;
            n_channels = 8'(req_n);
            program_size = 12'(req_size);
            start_req = 0;
        end else begin
            run = busy && ($urandom_range(4) == 0);
            n_channels = 8'($urandom);
            program_size = 12'($urandom);
        end
    endtask

    task automatic start(int n, int size, int d);
        obs = "";
        req_n = n;
        req_size = size;
        req_d = d;
        start_req = 1;
        step();
        build(n, size, d);
    endtask

    task automatic finish_prog();
        int guard = 0;
        while (q.size() > 0 && guard < 20000) begin
            step();
            guard++;
        end
        step();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = NOP;
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        n_channels = '0;
        program_size = '0;
        {immediate_advance, efi_call, stop_detected, efi_done} = '0;
        clear_prog();
        repeat (3) @(posedge clock);
        step();
        reset = 1'b0;
        step();

        start(3, 4, 1);
        chk("plain_trace_len", q.size(), 17);
        finish_prog();
        chk_str("plain_addrs", obs, "0 1 2 3 ");

        clear_prog();
        prog[1] = LDC;
        start(2, 5, 1);
        finish_prog();
        chk_str("ldc_addrs", obs, "0 1 3 4 ");

        clear_prog();
        prog[0] = LDC;
        start(1, 4, 1);
        finish_prog();
        chk_str("ldc_n1_addrs", obs, "0 2 3 ");

        clear_prog();
        start(0, 3, 1);
        finish_prog();
        chk_str("n0_addrs", obs, "0 1 2 ");

        clear_prog();
        prog[2] = EFI;
        start(2, 5, 10);
        chk("efi_trace_len", q.size(), 26);
        finish_prog();
        chk_str("efi_addrs", obs, "0 1 2 3 4 ");

        clear_prog();
        prog[1] = STOP;
        start(3, 100, 1);
        finish_prog();
        chk_str("stop_addrs", obs, "0 1 ");

        clear_prog();
        start(2, 0, 1);
        finish_prog();
        chk_str("size0_addrs", obs, "0 ");

        clear_prog();
        start(4, 50, 1);
        repeat (7) step();
        q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_str("reset_mid_addrs", obs, "0 1 ");
        start(2, 3, 1);
        finish_prog();
        chk_str("restart_addrs", obs, "0 1 2 ");

        for (int t = 0; t < 25; t++) begin
            int r, n;
            clear_prog();
            for (int i = 0; i < 20; i++) begin
                r = $urandom_range(99);
                prog[i] = (r < 55) ? NOP : (r < 75) ? LDC : (r < 90) ? EFI : STOP;
            end
            n = ($urandom_range(9) == 0) ? 255 : $urandom_range(4);
            start(n, $urandom_range(14), $urandom_range(1, 6));
            finish_prog();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
